// File: rtl/reprog_pkg.sv
// Shared types and constants for the framed reprogramming loader.
package reprog_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR0,
    ADDR1,
    LEN0,
    LEN1,
    DATA,
    CKSUM
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC = 8'h55;

  typedef logic [15:0] count_t;

endpackage

// File: rtl/reprog_word_pack.sv
// Packs an LSB-first byte stream into BYTES-wide words; word/word_valid include the byte
// presented this cycle so the completed word can be registered on the accepting edge.
module reprog_word_pack #(
  parameter  int BYTES  = 4,
  localparam int DATA_W = 8 * BYTES,
  localparam int CNT_W  = (BYTES > 1) ? $clog2(BYTES) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic [DATA_W-1:0] word,
  output logic              word_valid
);

  logic [CNT_W-1:0] byte_cnt;
  logic             last_byte;

  assign last_byte  = (byte_cnt == CNT_W'(BYTES - 1));
  assign word_valid = byte_valid & last_byte;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_cnt <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (byte_valid) begin
      byte_cnt <= last_byte ? '0 : byte_cnt + CNT_W'(1);
    end
  end

  generate
    if (BYTES > 1) begin : g_multi
      // Holds the earlier bytes of the word; the newest byte lands on top, oldest at bit 0.
      logic [DATA_W-9:0] shift_q;

      assign word = {byte_data, shift_q};

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          shift_q <= '0;
        end else if (clear) begin
          shift_q <= '0;
        end else if (byte_valid) begin
          shift_q <= word[DATA_W-1:8];
        end
      end
    end else begin : g_single
      assign word = byte_data;
    end
  endgenerate

endmodule

// File: rtl/reprog_loader.sv
// Framed stream loader between the host memory port and a byte-enabled RAM.
// Optional checksum byte and verification enabled by defining REPROG_CHECKSUM_EN.
module reprog_loader
  import reprog_pkg::*;
#(
  parameter  int         ADDR_WIDTH = 12,
  parameter  int         BYTES      = 4,
  parameter  logic [7:0] SYNC       = DEFAULT_SYNC,
  localparam int         DATA_W     = 8 * BYTES
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  prog_en,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [BYTES-1:0]      we_in,
  input  logic                  en_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [DATA_W-1:0]     data_out,
  output logic [BYTES-1:0]      we_out,
  output logic                  en_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  state_t state, state_nxt;

  logic                  accept;
  logic                  frame_start;
  logic                  abort;
  logic                  pack_valid;
  logic                  word_valid;
  logic                  last_word;
  logic [DATA_W-1:0]     word;
  logic [7:0]            addr_lo;
  logic [7:0]            len_lo;
  count_t                len_full;
  count_t                words_left;
  logic [ADDR_WIDTH-1:0] next_addr;

  logic                  wr_en;
  logic [BYTES-1:0]      wr_we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_W-1:0]     wr_data;

`ifdef REPROG_CHECKSUM_EN
  logic [7:0] cksum;
  logic [7:0] cksum_sum;
  assign cksum_sum = cksum + s_data;
`else
  logic done_pending;
`endif

  assign accept    = prog_en & s_valid;
  assign len_full  = {s_data, len_lo};
  assign last_word = word_valid && (words_left == count_t'(1));

  assign s_ready  = prog_en;
  assign busy     = (state != IDLE);
  assign addr_out = prog_en ? wr_addr : addr_in;
  assign data_out = prog_en ? wr_data : data_in;
  assign we_out   = prog_en ? wr_we   : we_in;
  assign en_out   = prog_en ? wr_en   : en_in;

  reprog_word_pack #(
    .BYTES(BYTES)
  ) u_pack (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (frame_start | abort),
    .byte_valid(pack_valid),
    .byte_data (s_data),
    .word      (word),
    .word_valid(word_valid)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Leaving programming mode always parks the FSM; doing so mid-frame is an abort.
  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    abort       = 1'b0;
    pack_valid  = 1'b0;
    if (!prog_en) begin
      state_nxt = IDLE;
      abort     = (state != IDLE);
    end else if (s_valid) begin
      case (state)
        IDLE: begin
          if (s_data == SYNC) begin
            state_nxt   = ADDR0;
            frame_start = 1'b1;
          end
        end
        ADDR0: state_nxt = ADDR1;
        ADDR1: state_nxt = LEN0;
        LEN0:  state_nxt = LEN1;
        LEN1: begin
          if (len_full == '0) begin
`ifdef REPROG_CHECKSUM_EN
            state_nxt = CKSUM;
`else
            state_nxt = IDLE;
`endif
          end else begin
            state_nxt = DATA;
          end
        end
        DATA: begin
          pack_valid = 1'b1;
          if (last_word) begin
`ifdef REPROG_CHECKSUM_EN
            state_nxt = CKSUM;
`else
            state_nxt = IDLE;
`endif
          end
        end
`ifdef REPROG_CHECKSUM_EN
        CKSUM:   state_nxt = IDLE;
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_lo    <= '0;
      len_lo     <= '0;
      words_left <= '0;
      next_addr  <= '0;
      wr_en      <= 1'b0;
      wr_we      <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef REPROG_CHECKSUM_EN
      cksum      <= '0;
`else
      done_pending <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      wr_we <= '0;
      done  <= 1'b0;

      if (frame_start) begin
        err <= 1'b0;
      end else if (abort) begin
        err <= 1'b1;
      end

      if (accept) begin
        case (state)
          ADDR0:   addr_lo    <= s_data;
          ADDR1:   next_addr  <= ADDR_WIDTH'({s_data, addr_lo});
          LEN0:    len_lo     <= s_data;
          LEN1:    words_left <= len_full;
          default: ;
        endcase
      end

      // Completed words become a single full-width write pulse on the next cycle.
      if (word_valid) begin
        wr_en      <= 1'b1;
        wr_we      <= '1;
        wr_addr    <= next_addr;
        wr_data    <= word;
        next_addr  <= next_addr + ADDR_WIDTH'(1);
        words_left <= words_left - count_t'(1);
      end

`ifdef REPROG_CHECKSUM_EN
      if (frame_start) begin
        cksum <= '0;
      end else if (accept && state != IDLE) begin
        cksum <= cksum_sum;
      end
      if (accept && state == CKSUM) begin
        if (cksum_sum == '0) begin
          done <= 1'b1;
        end else begin
          err <= 1'b1;
        end
      end
`else
      // done trails the final write by a cycle so the two never overlap.
      done_pending <= last_word;
      if (done_pending || (accept && state == LEN1 && len_full == '0)) begin
        done <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_reprog_loader.sv
// Self-checking bench for reprog_loader: passthrough vector table, hand-built frames and
// randomized frames checked against a frame-level model; follows REPROG_CHECKSUM_EN.
module tb_reprog_loader;

  localparam int         AW   = 12;
  localparam int         BY   = 4;
  localparam int         DW   = 8 * BY;
  localparam logic [7:0] SYNC = 8'h55;

  logic          clk;
  logic          rstn;
  logic          prog_en;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic [BY-1:0] we_in;
  logic          en_in;
  logic [AW-1:0] addr_out;
  logic [DW-1:0] data_out;
  logic [BY-1:0] we_out;
  logic          en_out;
  logic          busy;
  logic          done;
  logic          err;

  reprog_loader #(
    .ADDR_WIDTH(AW),
    .BYTES     (BY),
    .SYNC      (SYNC)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .prog_en (prog_en),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .addr_in (addr_in),
    .data_in (data_in),
    .we_in   (we_in),
    .en_in   (en_in),
    .addr_out(addr_out),
    .data_out(data_out),
    .we_out  (we_out),
    .en_out  (en_out),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          pe;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BY-1:0] we;
    logic          en;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    logic [BY-1:0] exp_we;
    logic          exp_en;
    logic          exp_rdy;
  } vec_t;

  int            checks;
  int            errors;
  int            done_cnt;
  bit            random_gaps;
  logic [AW-1:0] got_addr[$];
  logic [DW-1:0] got_data[$];
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];
  logic [7:0]    payload[$];
  vec_t          vecs[4];

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  // RAM-side observer: records loader writes and checks every done pulse.
  always @(negedge clk) begin
    if (rstn && prog_en && en_out) begin
      got_addr.push_back(addr_out);
      got_data.push_back(data_out);
      check_output("write_we_all_ones", 64'(we_out), 64'hF);
    end
    if (rstn && done) begin
      done_cnt++;
      check_output("done_not_with_write", 64'(en_out & prog_en), 64'h0);
    end
  end

  task automatic apply_stimulus(input vec_t v, input int idx);
    prog_en = v.pe;
    addr_in = v.a;
    data_in = v.d;
    we_in   = v.we;
    en_in   = v.en;
    #1;
    check_output($sformatf("vec%0d_addr", idx), 64'(addr_out), 64'(v.exp_a));
    check_output($sformatf("vec%0d_data", idx), 64'(data_out), 64'(v.exp_d));
    check_output($sformatf("vec%0d_we", idx), 64'(we_out), 64'(v.exp_we));
    check_output($sformatf("vec%0d_en", idx), 64'(en_out), 64'(v.exp_en));
    check_output($sformatf("vec%0d_ready", idx), 64'(s_ready), 64'(v.exp_rdy));
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    if (random_gaps && $urandom_range(0, 3) == 0) begin
      s_valid = 1'b0;
      s_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    s_data  = b;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected writes: word k goes to (start + k) mod 2^AW, bytes assembled little-endian.
  function automatic void model_frame(input logic [15:0] start, input int n);
    int            a;
    logic [DW-1:0] w;
    for (int k = 0; k < n; k++) begin
      a = (int'(start) + k) % (1 << AW);
      w = '0;
      for (int b = 0; b < BY; b++) begin
        w = w + (DW'(payload[k * BY + b]) << (8 * b));
      end
      exp_addr.push_back(AW'(a));
      exp_data.push_back(w);
    end
  endfunction

  task automatic send_frame(input logic [15:0] start, input int n, input logic [7:0] delta);
    logic [7:0] sum;
    logic [7:0] hdr[4];
    sum = 8'h00;
    hdr = '{start[7:0], start[15:8], n[7:0], n[15:8]};
    send_byte(SYNC);
    for (int i = 0; i < 4; i++) begin
      send_byte(hdr[i]);
      sum = sum + hdr[i];
    end
    for (int i = 0; i < payload.size(); i++) begin
      send_byte(payload[i]);
      sum = sum + payload[i];
    end
`ifdef REPROG_CHECKSUM_EN
    send_byte(8'(8'h00 - sum + delta));
`else
    if (delta != 8'h00) $display("[TB] note: checksum delta ignored without checksum byte");
`endif
  endtask

  task automatic verify_frame(input string tag, input bit exp_done, input bit exp_err);
    wait_cycles(3);
    check_output({tag, "_write_count"}, 64'(got_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check_output($sformatf("%s_addr%0d", tag, i), 64'(got_addr[i]), 64'(exp_addr[i]));
      check_output($sformatf("%s_data%0d", tag, i), 64'(got_data[i]), 64'(exp_data[i]));
    end
    check_output({tag, "_done_count"}, 64'(done_cnt), 64'(exp_done));
    check_output({tag, "_err"}, 64'(err), 64'(exp_err));
    check_output({tag, "_busy"}, 64'(busy), 64'h0);
    got_addr.delete();
    got_data.delete();
    exp_addr.delete();
    exp_data.delete();
    payload.delete();
    done_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] start;
    logic [7:0]  delta;
    logic [7:0]  b;
    int          n;
    int          stray;

    checks      = 0;
    errors      = 0;
    done_cnt    = 0;
    random_gaps = 1'b0;
    rstn        = 1'b0;
    prog_en     = 1'b0;
    s_valid     = 1'b0;
    s_data      = 8'h00;
    addr_in     = '0;
    data_in     = '0;
    we_in       = '0;
    en_in       = 1'b0;

    vecs[0] = '{1'b0, 12'h005, 32'hDEADBEEF, 4'hF, 1'b1, 12'h005, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 12'hFFF, 32'h01234567, 4'h3, 1'b0, 12'hFFF, 32'h01234567, 4'h3, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 12'h005, 32'hDEADBEEF, 4'hF, 1'b1, 12'h000, 32'h00000000, 4'h0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 12'h0AB, 32'hCAFEF00D, 4'h8, 1'b1, 12'h0AB, 32'hCAFEF00D, 4'h8, 1'b1, 1'b0};

    // Reset state, observed through the loader-owned port.
    #12;
    prog_en = 1'b1;
    #1;
    check_output("reset_busy", 64'(busy), 64'h0);
    check_output("reset_done", 64'(done), 64'h0);
    check_output("reset_err", 64'(err), 64'h0);
    check_output("reset_en_out", 64'(en_out), 64'h0);
    check_output("reset_we_out", 64'(we_out), 64'h0);
    check_output("reset_addr_out", 64'(addr_out), 64'h0);
    check_output("reset_data_out", 64'(data_out), 64'h0);
    prog_en = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    wait_cycles(1);

    for (int i = 0; i < 4; i++) apply_stimulus(vecs[i], i);
    prog_en = 1'b1;
    addr_in = '0;
    data_in = '0;
    we_in   = '0;
    en_in   = 1'b0;
    wait_cycles(1);

    // Reference frame with cycle-exact write and done timing.
    payload = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    model_frame(16'h0010, 2);
    send_byte(SYNC);
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    check_output("spec_busy_mid", 64'(busy), 64'h1);
    send_byte(8'h44);
    check_output("spec_w0_en", 64'(en_out), 64'h1);
    check_output("spec_w0_addr", 64'(addr_out), 64'h010);
    check_output("spec_w0_data", 64'(data_out), 64'h44332211);
    send_byte(8'h55);
    check_output("spec_w0_one_cycle", 64'(en_out), 64'h0);
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
    check_output("spec_w1_en", 64'(en_out), 64'h1);
    check_output("spec_w1_addr", 64'(addr_out), 64'h011);
    check_output("spec_w1_data", 64'(data_out), 64'h88776655);
`ifdef REPROG_CHECKSUM_EN
    send_byte(8'h8A);
    check_output("spec_done_timing", 64'(done), 64'h1);
`else
    check_output("spec_done_not_early", 64'(done), 64'h0);
    wait_cycles(1);
    check_output("spec_done_timing", 64'(done), 64'h1);
`endif
    verify_frame("spec_frame", 1'b1, 1'b0);

`ifdef REPROG_CHECKSUM_EN
    // Bad checksum keeps the writes, flags err until the next SYNC; then an empty frame.
    payload = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    model_frame(16'h0010, 2);
    send_frame(16'h0010, 2, 8'h01);
    verify_frame("bad_cksum", 1'b0, 1'b1);
    send_byte(8'h00);
    send_byte(8'hAA);
    check_output("err_sticky", 64'(err), 64'h1);
    send_byte(SYNC);
    check_output("err_clear_on_sync", 64'(err), 64'h0);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    check_output("n0_done_after_cksum", 64'(done), 64'h1);
    verify_frame("n0_frame", 1'b1, 1'b0);
`else
    send_byte(8'h00);
    send_byte(8'hAA);
    check_output("stray_not_busy", 64'(busy), 64'h0);
    send_byte(SYNC);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    check_output("n0_done_after_len1", 64'(done), 64'h1);
    verify_frame("n0_frame", 1'b1, 1'b0);
`endif

    // Address wrap at the top of a 12-bit RAM.
    for (int i = 0; i < 2 * BY; i++) payload.push_back(8'($urandom));
    model_frame(16'h0FFF, 2);
    send_frame(16'h0FFF, 2, 8'h00);
    verify_frame("wrap", 1'b1, 1'b0);

    // Abort after three payload bytes, with host traffic taking over at once.
    send_byte(SYNC);
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    check_output("abort_busy_before", 64'(busy), 64'h1);
    prog_en = 1'b0;
    addr_in = 12'h007;
    data_in = 32'h12345678;
    we_in   = 4'h3;
    en_in   = 1'b1;
    #1;
    check_output("abort_pass_addr", 64'(addr_out), 64'h007);
    check_output("abort_pass_data", 64'(data_out), 64'h12345678);
    check_output("abort_pass_we", 64'(we_out), 64'h3);
    check_output("abort_pass_en", 64'(en_out), 64'h1);
    check_output("abort_ready", 64'(s_ready), 64'h0);
    wait_cycles(1);
    check_output("abort_busy_after", 64'(busy), 64'h0);
    check_output("abort_err", 64'(err), 64'h1);
    addr_in = '0;
    data_in = '0;
    we_in   = '0;
    en_in   = 1'b0;
    verify_frame("abort", 1'b0, 1'b1);
    prog_en = 1'b1;

    // Asynchronous reset in the middle of a frame.
    send_byte(SYNC);
    send_byte(8'h01);
    check_output("rst_mid_busy_before", 64'(busy), 64'h1);
    #2;
    rstn = 1'b0;
    #1;
    check_output("rst_mid_busy", 64'(busy), 64'h0);
    check_output("rst_mid_err", 64'(err), 64'h0);
    check_output("rst_mid_en_out", 64'(en_out), 64'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    wait_cycles(1);

    // Randomized frames with stray bytes, idle gaps and (when enabled) corrupted checksums.
    random_gaps = 1'b1;
    for (int f = 0; f < 10; f++) begin
      stray = $urandom_range(0, 2);
      for (int i = 0; i < stray; i++) begin
        b = 8'($urandom_range(0, 255));
        if (b == SYNC) b = 8'h00;
        send_byte(b);
      end
      start = 16'($urandom);
      n     = $urandom_range(0, 5);
      for (int i = 0; i < n * BY; i++) payload.push_back(8'($urandom));
`ifdef REPROG_CHECKSUM_EN
      delta = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
`else
      delta = 8'h00;
`endif
      model_frame(start, n);
      send_frame(start, n, delta);
      verify_frame($sformatf("rand%0d", f), delta == 8'h00, delta != 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
